// File: rtl/train_actuator_driver.sv
// Output stage of the train controller: decodes the latched controller state into
// motor/light/gate drives and sequences every change (reversal dead time, settle dwell).
module train_actuator_driver #(
  parameter int TIMER_W      = 16,
  parameter int DEAD_TICKS   = 50,
  parameter int SETTLE_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] present_state,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic [1:0] speed,
  output logic       light_green,
  output logic       light_red,
  output logic       gate_down,
  output logic       fault,
  output logic       busy,
  output logic       act_done
);

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    APPLY,
    SETTLE,
    DONE
  } state_t;

  typedef struct packed {
    logic       fwd;
    logic       rev;
    logic [1:0] speed;
    logic       green;
    logic       red;
    logic       gate;
    logic       fault;
  } act_t;

  localparam act_t RESET_ACT = 8'h04;
  localparam logic [TIMER_W-1:0] DEAD_LOAD   = TIMER_W'(DEAD_TICKS);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_TICKS);

  // States 5..7 reuse the low two bits as the speed level, just like 1..3.
  function automatic act_t decode(input logic [3:0] s);
    act_t a;
    a = '0;
    if (s[3]) begin
      a.red   = 1'b1;
      a.gate  = 1'b1;
      a.fault = 1'b1;
    end else if (s[1:0] == 2'd0) begin
      a.red  = 1'b1;
      a.gate = s[2];
    end else begin
      a.fwd   = ~s[2];
      a.rev   = s[2];
      a.speed = s[1:0];
      a.green = 1'b1;
      a.gate  = s[2];
    end
    return a;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         latched_q, latched_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  act_t               act_q, act_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic mismatch;
  logic new_fwd;
  logic new_rev;
  logic reversal;
  logic restart;

  assign mismatch = (present_state != latched_q);
  assign new_fwd  = ~present_state[3] & ~present_state[2] & (present_state[1:0] != 2'd0);
  assign new_rev  = ~present_state[3] &  present_state[2] & (present_state[1:0] != 2'd0);
  assign reversal = (act_q.fwd & new_rev) | (act_q.rev & new_fwd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      latched_q <= 4'd0;
      cnt_q     <= '0;
      act_q     <= RESET_ACT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // A new command seen in IDLE, APPLY or SETTLE restarts sequencing against what is
  // currently driven; DEAD only re-latches because the motor is already off.
  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    restart   = 1'b0;

    case (state_q)
      IDLE: begin
        restart = mismatch;
      end
      DEAD: begin
        if (mismatch) begin
          latched_d = present_state;
        end
        if (cnt_q == '0) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - TIMER_W'(1);
        end
      end
      APPLY: begin
        if (mismatch) begin
          restart = 1'b1;
        end else begin
          act_d   = decode(latched_q);
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (mismatch) begin
          restart = 1'b1;
        end else if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - TIMER_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (restart) begin
      latched_d = present_state;
      busy_d    = 1'b1;
      if (reversal) begin
        act_d.fwd   = 1'b0;
        act_d.rev   = 1'b0;
        act_d.speed = 2'd0;
        cnt_d       = DEAD_LOAD;
        state_d     = DEAD;
      end else begin
        state_d = APPLY;
      end
    end
  end

  assign motor_fwd   = act_q.fwd;
  assign motor_rev   = act_q.rev;
  assign speed       = act_q.speed;
  assign light_green = act_q.green;
  assign light_red   = act_q.red;
  assign gate_down   = act_q.gate;
  assign fault       = act_q.fault;
  assign busy        = busy_q;
  assign act_done    = done_q;

endmodule

// File: tb/tb_train_actuator_driver.sv
// Bench for train_actuator_driver: directed scenarios plus random state sequences,
// compared every cycle against a timestamp-based reference of the sequencing rules.
module tb_train_actuator_driver;

  localparam int DEAD   = 3;
  localparam int SETTLE = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] ps;
  logic       motor_fwd, motor_rev, light_green, light_red, gate_down, fault, busy, act_done;
  logic [1:0] speed;

  int testsRun    = 0;
  int testsFailed = 0;
  int actCount    = 0;
  int busyCount   = 0;
  int lastActSpeed = -1;

  train_actuator_driver #(
    .TIMER_W      (16),
    .DEAD_TICKS   (DEAD),
    .SETTLE_TICKS (SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .present_state (ps),
    .motor_fwd     (motor_fwd),
    .motor_rev     (motor_rev),
    .speed         (speed),
    .light_green   (light_green),
    .light_red     (light_red),
    .gate_down     (gate_down),
    .fault         (fault),
    .busy          (busy),
    .act_done      (act_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outputs as a table lookup, sequencing tracked by the edge numbers
  // at which the command is applied and at which act_done rises.
  typedef struct packed {
    logic       fwd;
    logic       rev;
    logic [1:0] spd;
    logic       grn;
    logic       red;
    logic       gate;
    logic       flt;
  } outs_t;

  outs_t      mOut;
  logic [3:0] mLatched;
  logic       mBusy;
  logic       mAct;
  int         edgeNum;
  int         applyAt;
  int         doneAt;

  function automatic outs_t specDecode(input int s);
    outs_t o;
    o = '0;
    if (s == 0) begin
      o.red = 1'b1;
    end else if (s >= 1 && s <= 3) begin
      o.fwd = 1'b1; o.spd = 2'(s); o.grn = 1'b1;
    end else if (s == 4) begin
      o.red = 1'b1; o.gate = 1'b1;
    end else if (s >= 5 && s <= 7) begin
      o.rev = 1'b1; o.spd = 2'(s - 4); o.grn = 1'b1; o.gate = 1'b1;
    end else begin
      o.red = 1'b1; o.gate = 1'b1; o.flt = 1'b1;
    end
    return o;
  endfunction

  function automatic int dirOf(input int s);
    if (s >= 1 && s <= 3) return 1;
    if (s >= 5 && s <= 7) return 2;
    return 0;
  endfunction

  task automatic startCommand(input int n);
    int drivenDir;
    drivenDir = mOut.fwd ? 1 : (mOut.rev ? 2 : 0);
    mLatched = ps;
    mBusy    = 1'b1;
    doneAt   = -1;
    if (drivenDir != 0 && dirOf(int'(ps)) != 0 && drivenDir != dirOf(int'(ps))) begin
      mOut.fwd = 1'b0;
      mOut.rev = 1'b0;
      mOut.spd = 2'd0;
      applyAt  = n + DEAD + 2;
    end else begin
      applyAt = n + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOut     = specDecode(0);
      mLatched = 4'd0;
      mBusy    = 1'b0;
      mAct     = 1'b0;
      edgeNum  = 0;
      applyAt  = 0;
      doneAt   = -1;
    end else begin
      edgeNum = edgeNum + 1;
      mAct    = 1'b0;
      if (!mBusy) begin
        if (ps != mLatched) startCommand(edgeNum);
      end else if (doneAt >= 0 && edgeNum == doneAt + 1) begin
        mBusy = 1'b0;
      end else if (edgeNum < applyAt) begin
        if (ps != mLatched) mLatched = ps;
      end else if (ps != mLatched) begin
        startCommand(edgeNum);
      end else if (edgeNum == applyAt) begin
        mOut   = specDecode(int'(mLatched));
        doneAt = edgeNum + SETTLE + 1;
      end else if (edgeNum == doneAt) begin
        mAct = 1'b1;
      end
    end
  end

  function automatic logic [9:0] dutVec();
    return {motor_fwd, motor_rev, speed, light_green, light_red, gate_down, fault, busy, act_done};
  endfunction

  function automatic logic [9:0] modelVec();
    return {mOut, mBusy, mAct};
  endfunction

  function automatic logic [9:0] expVec(input int f, input int r, input int s, input int g,
                                        input int rd, input int gt, input int ft, input int b,
                                        input int a);
    return {1'(f), 1'(r), 2'(s), 1'(g), 1'(rd), 1'(gt), 1'(ft), 1'(b), 1'(a)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun = testsRun + 1;
    if (observed !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance n cycles, checking the full output vector against the model at each negedge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("cycle", 32'(dutVec()), 32'(modelVec()));
      checkOutput("fwd_rev_excl", 32'(motor_fwd & motor_rev), 32'd0);
      if (act_done) begin
        actCount = actCount + 1;
        lastActSpeed = int'(speed);
      end
      if (busy) busyCount = busyCount + 1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] state, input int cycles);
    ps = state;
    tick(cycles);
  endtask

  int actBase;
  int busyBase;
  logic [3:0] randState;

  initial begin
    rst_n = 1'b0;
    ps    = 4'd0;
    tick(3);
    checkOutput("rst_outputs", 32'(dutVec()), 32'(expVec(0,0,0,0,1,0,0,0,0)));
    rst_n = 1'b1;

    actBase  = actCount;
    busyBase = busyCount;
    tick(20);
    checkOutput("rst_no_busy", 32'(busyCount - busyBase), 32'd0);
    checkOutput("rst_no_act", 32'(actCount - actBase), 32'd0);

    // Forward start 0->2
    actBase = actCount;
    applyStimulus(4'd2, 2);
    checkOutput("fwd_edge1", 32'(dutVec()), 32'(expVec(1,0,2,1,0,0,0,1,0)));
    tick(4);
    checkOutput("fwd_edge5_no_act", 32'(act_done), 32'd0);
    tick(1);
    checkOutput("fwd_edge6_act", 32'(dutVec()), 32'(expVec(1,0,2,1,0,0,0,1,1)));
    tick(1);
    checkOutput("fwd_edge7_idle", 32'(dutVec()), 32'(expVec(1,0,2,1,0,0,0,0,0)));
    checkOutput("fwd_pulses", 32'(actCount - actBase), 32'd1);

    // Reversal 2->5
    applyStimulus(4'd5, 1);
    checkOutput("rev_edge0_off", 32'(dutVec()), 32'(expVec(0,0,0,1,0,0,0,1,0)));
    tick(4);
    checkOutput("rev_edge4_dead", 32'(dutVec()), 32'(expVec(0,0,0,1,0,0,0,1,0)));
    tick(1);
    checkOutput("rev_edge5_apply", 32'(dutVec()), 32'(expVec(0,1,1,1,0,1,0,1,0)));
    tick(4);
    checkOutput("rev_edge9_no_act", 32'(act_done), 32'd0);
    tick(1);
    checkOutput("rev_edge10_act", 32'(act_done), 32'd1);
    tick(1);
    checkOutput("rev_edge11_idle", 32'(busy), 32'd0);

    // Abort: 0->1, then 1->3 while settling
    applyStimulus(4'd0, 12);
    actBase = actCount;
    applyStimulus(4'd1, 3);
    applyStimulus(4'd3, 15);
    checkOutput("abort_pulses", 32'(actCount - actBase), 32'd1);
    checkOutput("abort_pulse_speed", 32'(lastActSpeed), 32'd3);
    checkOutput("abort_final_speed", 32'(speed), 32'd3);

    // Fault: 1->12 then 12->0
    applyStimulus(4'd1, 12);
    actBase = actCount;
    applyStimulus(4'd12, 2);
    checkOutput("fault_edge1", 32'(dutVec()), 32'(expVec(0,0,0,0,1,1,1,1,0)));
    tick(10);
    checkOutput("fault_pulses", 32'(actCount - actBase), 32'd1);
    applyStimulus(4'd0, 12);
    checkOutput("fault_clear", 32'(fault), 32'd0);

    // Reset asserted mid-cycle while in DEAD
    applyStimulus(4'd1, 12);
    applyStimulus(4'd5, 2);
    checkOutput("midrst_in_dead", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_async", 32'(dutVec()), 32'(expVec(0,0,0,0,1,0,0,0,0)));
    ps = 4'd0;
    tick(2);
    rst_n = 1'b1;
    actBase = actCount;
    tick(12);
    checkOutput("midrst_no_act", 32'(actCount - actBase), 32'd0);

    // Random command sequences, including repeats and changes mid-sequence
    randState = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) randState = 4'($urandom_range(0, 15));
      applyStimulus(randState, $urandom_range(1, 14));
    end
    tick(20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
